// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Purpose  : Instruction-fetch front end. Issues sequential fetch requests
//             to a one-cycle-latency instruction SRAM, buffers responses in a
//             small FIFO and presents them to decode with a valid/ready
//             handshake. A redirect from execute flushes everything and
//             restarts fetch at the (word-aligned) target.
//
//  Ports    : clk              - sole clock, rising edge
//             rst_n            - asynchronous active-low reset
//             br_e / br_addr   - redirect request and target
//             inst_sram_en     - fetch request strobe
//             inst_sram_we     - byte write enables (always 0)
//             inst_sram_addr   - fetch address (= fetch PC)
//             inst_sram_wdata  - write data (always 0)
//             inst_sram_rdata  - 64-bit read data, valid one cycle after en
//             if_valid/if_ready- head-of-queue handshake toward decode
//             if_pc / if_inst  - PC and instruction of the head entry
//
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_queue #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = XLEN'(64'h8000_0000),
    parameter int                DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 br_e,
    input  logic [XLEN-1:0]      br_addr,
    output logic                 inst_sram_en,
    output logic [7:0]           inst_sram_we,
    output logic [XLEN-1:0]      inst_sram_addr,
    output logic [63:0]          inst_sram_wdata,
    input  logic [63:0]          inst_sram_rdata,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [XLEN-1:0]      if_pc,
    output logic [31:0]          if_inst
);

    // DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] count_t;
    // One extra bit so count + inflight can never wrap in the credit check.
    typedef logic [CW:0]   used_t;

    localparam count_t c_count_full = count_t'(DEPTH);
    localparam used_t  c_depth      = used_t'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic            r_inflight;
    count_t          r_count;
    ptr_t            r_wr_ptr;
    ptr_t            r_rd_ptr;

    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic [31:0]     r_mem_inst [DEPTH];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic            w_pop;
    logic            w_push;
    used_t           w_used;
    logic [31:0]     w_resp_inst;

    assign if_valid = (r_count != '0) & ~br_e;
    assign if_pc    = r_mem_pc[r_rd_ptr];
    assign if_inst  = r_mem_inst[r_rd_ptr];

    assign w_pop  = if_valid & if_ready;
    // A response arriving in a redirect cycle belongs to the old stream.
    assign w_push = r_inflight & ~br_e;

    // Credit check: every slot is reserved at request time, so a response
    // always finds room when it lands one cycle later.
    assign w_used = used_t'(r_count) + used_t'(r_inflight) - used_t'(w_pop);

    // rst_n gates the strobe directly so it drops the instant reset asserts.
    assign inst_sram_en    = rst_n & ~br_e & (w_used < c_depth);
    assign inst_sram_addr  = r_fetch_pc;
    assign inst_sram_we    = '0;
    assign inst_sram_wdata = '0;

    // The SRAM returns an aligned doubleword; PC bit 2 picks the word.
    assign w_resp_inst = r_resp_pc[2] ? inst_sram_rdata[63:32]
                                      : inst_sram_rdata[31:0];

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (br_e) begin
            r_fetch_pc <= {br_addr[XLEN-1:2], 2'b00};
            r_inflight <= 1'b0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (inst_sram_en) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_resp_pc  <= r_fetch_pc;
            end
            r_inflight <= inst_sram_en;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + count_t'(1);
                2'b01:   r_count <= r_count - count_t'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage (data only, no reset needed)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
            r_mem_inst[r_wr_ptr] <= w_resp_inst;
        end
    end

    // A push into a full queue means the credit check has been broken.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(w_push && (r_count == c_count_full))
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Purpose  : Directed self-checking bench for if_fetch_queue. A small
//             one-cycle-latency SRAM model answers fetches; every expected
//             PC and instruction is a hand-derived constant.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        br_e;
    logic [63:0] br_addr;
    logic        inst_sram_en;
    logic [7:0]  inst_sram_we;
    logic [63:0] inst_sram_addr;
    logic [63:0] inst_sram_wdata;
    logic [63:0] inst_sram_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_inst;

    logic        force_pat;
    int          n_pass;
    int          n_total;

    if_fetch_queue #(
        .XLEN     (64),
        .RESET_PC (64'h8000_0000),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .br_e            (br_e),
        .br_addr         (br_addr),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word stored at a given PC in the SRAM model.
    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0000;
    endfunction

    // SRAM: doubleword read, data appears one cycle after the request.
    always @(posedge clk) begin
        if (inst_sram_en) begin
            if (force_pat)
                inst_sram_rdata <= 64'hAAAA_AAAA_BBBB_BBBB;
            else
                inst_sram_rdata <= {inst_of(inst_sram_addr | 64'h4),
                                    inst_of(inst_sram_addr & ~64'h7)};
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic expect_head(input string tag, input logic [63:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {63'd0, if_valid}, 64'd1);
        chk({tag, "_pc"},    if_pc, pc);
        chk({tag, "_inst"},  {32'd0, if_inst}, {32'd0, inst});
    endtask

    initial begin
        n_pass          = 0;
        n_total         = 0;
        rst_n           = 1'b0;
        br_e            = 1'b0;
        br_addr         = '0;
        if_ready        = 1'b1;
        force_pat       = 1'b0;
        inst_sram_rdata = '0;

        // Held in reset
        @(negedge clk); #1;
        chk("rst_en",    {63'd0, inst_sram_en}, 64'd0);
        chk("rst_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_addr",  inst_sram_addr, 64'h8000_0000);
        chk("tie_we",    {56'd0, inst_sram_we}, 64'd0);
        chk("tie_wdata", inst_sram_wdata, 64'd0);

        // Cycle 0: first request at the reset PC
        @(negedge clk); rst_n = 1'b1; #1;
        chk("c0_en",   {63'd0, inst_sram_en}, 64'd1);
        chk("c0_addr", inst_sram_addr, 64'h8000_0000);

        // Cycle 1: second request, nothing visible yet
        @(negedge clk); #1;
        chk("c1_addr",  inst_sram_addr, 64'h8000_0004);
        chk("c1_valid", {63'd0, if_valid}, 64'd0);

        // Cycles 2..4: one instruction per cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            expect_head("stream", 64'h8000_0000 + 64'(4 * i), inst_of(64'h8000_0000 + 64'(4 * i)));
        end

        // Decode stalls for 10 cycles: queue fills to 4 and fetch stops
        if_ready = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("full_en", {63'd0, inst_sram_en}, 64'd0);
        expect_head("full_head", 64'h8000_0008, inst_of(64'h8000_0008));

        // Drain in order
        if_ready = 1'b1; #1;
        chk("drain_en", {63'd0, inst_sram_en}, 64'd1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk); #1;
            expect_head("drain", 64'h8000_0008 + 64'(4 * i), inst_of(64'h8000_0008 + 64'(4 * i)));
        end

        // Redirect with 3 queued, 1 in flight, push and pop both pending
        br_e = 1'b1; br_addr = 64'h8000_0100; #1;
        chk("flush_valid", {63'd0, if_valid}, 64'd0);
        chk("flush_en",    {63'd0, inst_sram_en}, 64'd0);

        @(negedge clk); br_e = 1'b0; #1;
        chk("redir_addr",  inst_sram_addr, 64'h8000_0100);
        chk("redir_en",    {63'd0, inst_sram_en}, 64'd1);
        chk("redir_valid", {63'd0, if_valid}, 64'd0);

        @(negedge clk); #1;
        chk("redir_valid2", {63'd0, if_valid}, 64'd0);
        chk("redir_addr2",  inst_sram_addr, 64'h8000_0104);

        @(negedge clk); #1;
        expect_head("redir_head", 64'h8000_0100, inst_of(64'h8000_0100));
        @(negedge clk); #1;
        expect_head("redir_next", 64'h8000_0104, inst_of(64'h8000_0104));

        // Misaligned redirect target and lane selection
        br_e = 1'b1; br_addr = 64'h8000_0203; force_pat = 1'b1; #1;
        chk("flush2_valid", {63'd0, if_valid}, 64'd0);

        @(negedge clk); br_e = 1'b0; #1;
        chk("align_addr", inst_sram_addr, 64'h8000_0200);
        chk("align_en",   {63'd0, inst_sram_en}, 64'd1);

        @(negedge clk); #1;
        @(negedge clk); #1;
        expect_head("lane_lo", 64'h8000_0200, 32'hBBBB_BBBB);
        @(negedge clk); #1;
        expect_head("lane_hi", 64'h8000_0204, 32'hAAAA_AAAA);

        // Fill the queue, then pulse reset asynchronously mid-cycle
        force_pat = 1'b0;
        if_ready  = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("full2_en", {63'd0, inst_sram_en}, 64'd0);
        expect_head("full2_head", 64'h8000_0204, 32'hAAAA_AAAA);

        #1; rst_n = 1'b0; #1;
        chk("arst_valid", {63'd0, if_valid}, 64'd0);
        chk("arst_en",    {63'd0, inst_sram_en}, 64'd0);
        chk("arst_addr",  inst_sram_addr, 64'h8000_0000);

        @(negedge clk); rst_n = 1'b1; if_ready = 1'b1; #1;
        chk("rerun_en",   {63'd0, inst_sram_en}, 64'd1);
        chk("rerun_addr", inst_sram_addr, 64'h8000_0000);

        @(negedge clk); #1;
        chk("rerun_valid", {63'd0, if_valid}, 64'd0);
        chk("rerun_addr2", inst_sram_addr, 64'h8000_0004);

        @(negedge clk); #1;
        expect_head("rerun_head", 64'h8000_0000, inst_of(64'h8000_0000));
        @(negedge clk); #1;
        expect_head("rerun_next", 64'h8000_0004, inst_of(64'h8000_0004));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
